cascade_counter: RTL
====================

# cascade_counter

Parametrised multi-stage modulo counter with runtime per-stage modulus, up/down direction, synchronous clear/load and three end-of-count modes (wrap, saturate, one-shot). Stages ripple-enable from stage 0 (least significant) upward, forming mixed-radix counters such as sec/min/hour or prescaler+divider chains. It replaces single fixed-modulus counters wherever direction, runtime modulus or terminal behaviour must be selectable.

## Interface
- STAGES, 2, number of cascaded stages (>=1)
- W, 8, bits per stage
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- en  in  1  count enable for stage 0
- up  in  1  1 = count up, 0 = count down
- clr  in  1  synchronous clear
- load  in  1  synchronous parallel load
- load_val  in  STAGES x W  load value per stage
- mod_val  in  STAGES x W  modulus per stage; 0 means 2^W
- mode  in  2  end-of-count mode: WRAP=0, SAT=1, ONESHOT=2, 3 treated as WRAP
- cnt  out  STAGES x W  stage values, registered
- co  out  1  chain terminal carry/borrow, combinational
- done  out  1  chain stopped (SAT/ONESHOT), registered

## Operation
- Per stage i: M_i = mod_val[i] (2^W if 0). Terminal t_i: up -> cnt[i] >= M_i-1; down -> cnt[i] == 0.
- Stage enable: e_0 = en & RUN; e_i = e_{i-1} & t_{i-1}. all_t = AND of all t_i.
- Enabled stage, up: t_i -> 0, else +1. Down: cnt[i] == 0 or cnt[i] > M_i-1 -> M_i-1, else -1.
- co = en & RUN & all_t.
- FSM (state RUN/STOP): RUN -> STOP on co when mode is SAT or ONESHOT; STOP -> RUN only on clr or load. WRAP never leaves RUN.
- On co in WRAP: every stage wraps per stage rule (full rollover).
- On co in SAT: no stage changes; counter holds terminal value.
- On co in ONESHOT: every stage wraps once (up -> all 0; down -> all M_i-1), then stops.
- In STOP: cnt holds, co = 0, en ignored, mode/up changes ignored.
- Priority: clr > load > count. clr: all cnt = 0, state RUN. load: cnt = load_val (unclamped), state RUN.
- mod_val may change any cycle; out-of-range stage values resolve by the terminal/down rules on the stage's next enabled cycle.
- M_i = 1: stage always terminal, stays 0.
- done = (state == STOP).

## Timing
- Reset (rst_n low, async): cnt = 0, state RUN, done = 0; co = 0 while reset held.
- cnt updates on the edge following an enabled cycle; latency 1.
- co is combinational, valid in the same cycle as the terminal value with en high; consumers sample it on that edge.
- done asserts the cycle after the edge at which co was high (SAT/ONESHOT); deasserts the cycle after clr/load.
- clr or load coincident with co: clr/load wins, no STOP transition, no wrap.
- rst_n asserted mid-count: immediate return to reset values; first count after deassertion is the first enabled edge.
- Direction change mid-count takes effect on the next enabled edge; no extra cycle.

## Structure
- Package counter_pkg: mode_e enum (WRAP, SAT, ONESHOT), state_e enum (RUN, STOP), helper function computing effective modulus from (mod_val, W).
- Sub-module counter_cell: one stage; inputs clk, rst_n, clr, load, load_val, mod_val, up, inc (stage enable), hold (SAT/STOP suppression); outputs cnt, term. Top generates STAGES cells, enable chain, co and FSM.

## Test plan
- STAGES=2, W=8, mod_val={60,60}, WRAP, up, en=1 from reset: cnt goes {0,0}->{59,59} in 3599 cycles, co high exactly on cycle 3599, next cnt {0,0}, done stays 0.
- Same, down from reset: first edge -> {59,59} via borrow? No: stage 0 at 0 with e_0 -> 59, stage 1 enabled (t_0) -> 59; co high on that first cycle; counts down to {0,0} after 3599 more edges.
- SAT, up, mod_val={10,3}: holds at {9,2}, co one cycle, done=1 next cycle; en stays high, cnt unchanged 20 cycles; load {4,1} -> cnt {4,1}, done 0.
- ONESHOT, up, mod_val={4,0}: after 1024 enabled edges cnt {0,0}, done=1, further en ignored; clr -> RUN, counting resumes.
- load {200,5} with mod_val={100,10}, up: next enabled edge stage 0 -> 0 and stage 1 -> 6; down from same load: stage 0 -> 99, stage 1 holds 5.
- clr and load and co in same cycle -> cnt {0,0}, done 0; rst_n pulse low mid-count -> cnt {0,0} immediately, done 0.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared types and helpers for the cascaded modulo counter.
package counter_pkg;

   typedef enum logic [1:0] {
      WRAP    = 2'd0,
      SAT     = 2'd1,
      ONESHOT = 2'd2
   } mode_e;

   typedef enum logic {
      RUN  = 1'b0,
      STOP = 1'b1
   } state_e;

   // A programmed modulus of 0 selects the full 2^w range; w must be <= 32.
   function automatic logic [32:0] eff_mod(input logic [31:0] mod_val, input int unsigned w);
      eff_mod = (mod_val == 32'd0) ? (33'd1 << w) : {1'b0, mod_val};
   endfunction

endpackage

// File: rtl/counter_cell.sv
// One counter stage: modulo up/down count with clear/load and a terminal flag.
module counter_cell
   import counter_pkg::*;
#(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic [W-1:0] mod_val,
   input  logic         up,
   input  logic         inc,
   input  logic         hold,
   output logic [W-1:0] cnt,
   output logic         term
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;
   logic [W-1:0] last;
   logic [32:0]  m_eff;

   assign m_eff = eff_mod(32'(mod_val), W);
   assign last  = W'(m_eff - 33'd1);

   // Out-of-range values count as terminal going up, so they fold back to 0.
   assign term = up ? (cnt_q >= last) : (cnt_q == '0);

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (load) begin
         cnt_d = load_val;
      end else if (inc && !hold) begin
         if (up) begin
            cnt_d = term ? '0 : cnt_q + W'(1);
         end else begin
            cnt_d = ((cnt_q == '0) || (cnt_q > last)) ? last : cnt_q - W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/cascade_counter.sv
// Mixed-radix chain of counter_cell stages with wrap / saturate / one-shot end of count.
module cascade_counter
   import counter_pkg::*;
#(
   parameter int STAGES = 2,
   parameter int W      = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    en,
   input  logic                    up,
   input  logic                    clr,
   input  logic                    load,
   input  logic [STAGES-1:0][W-1:0] load_val,
   input  logic [STAGES-1:0][W-1:0] mod_val,
   input  logic [1:0]              mode,
   output logic [STAGES-1:0][W-1:0] cnt,
   output logic                    co,
   output logic                    done
);

   state_e            state_q;
   state_e            state_d;
   logic [STAGES-1:0] term;
   logic [STAGES-1:0] inc;
   logic              run;
   logic              stop_mode;
   logic              hold;

   assign run       = (state_q == RUN);
   assign stop_mode = (mode == SAT) || (mode == ONESHOT);
   assign co        = rst_n & en & run & (&term);
   // Saturation freezes every stage on the terminal cycle instead of rolling over.
   assign hold      = co & (mode == SAT);

   for (genvar g = 0; g < STAGES; g++) begin : g_stage
      if (g == 0) begin : g_first
         assign inc[g] = en & run;
      end else begin : g_rest
         assign inc[g] = en & run & (&term[g-1:0]);
      end

      counter_cell #(
         .W(W)
      ) u_cell (
         .clk      (clk),
         .rst_n    (rst_n),
         .clr      (clr),
         .load     (load),
         .load_val (load_val[g]),
         .mod_val  (mod_val[g]),
         .up       (up),
         .inc      (inc[g]),
         .hold     (hold),
         .cnt      (cnt[g]),
         .term     (term[g])
      );
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= RUN;
      end else begin
         state_q <= state_d;
      end
   end

   // clr/load beat a coincident terminal carry, so no STOP is entered then.
   always_comb begin
      state_d = state_q;
      if (clr || load) begin
         state_d = RUN;
      end else if (co && stop_mode) begin
         state_d = STOP;
      end
   end

   always_comb begin
      done = (state_q == STOP);
   end

endmodule
